// File: rtl/alu_addsub_stage.sv
// Add/subtract issue stage around an external ripple adder.
// Registers operands, captures sum and NZCV, hands off via valid/ready.
module alu_addsub_stage #(
   parameter int WIDTH = 32,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout,
   input  logic             add_z,
   input  logic             add_n,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             op_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [WIDTH-1:0] r_add_a;
   logic [WIDTH-1:0] r_add_b;
   logic             r_add_cin;
   logic             r_cmp;
   logic             r_rsv;
   logic [WIDTH-1:0] r_result;
   logic             r_n;
   logic             r_z;
   logic             r_c;
   logic             r_v;
   logic             r_err;

   logic             w_accept;
   logic [WIDTH-1:0] w_b;
   logic             w_cin;
   logic             w_cmp;
   logic             w_rsv;
   logic             w_v;

   assign w_accept = in_valid & in_ready;

   // Overflow: like-signed operands producing a differently signed sum
   assign w_v = (r_add_a[WIDTH-1] == r_add_b[WIDTH-1]) &
                (add_sum[WIDTH-1] != r_add_a[WIDTH-1]);

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (in_valid) w_next = BUSY;
         BUSY: w_next = HOLD;
         HOLD: begin
            if (out_ready) w_next = in_valid ? BUSY : IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Handshake outputs; in_ready follows out_ready in HOLD for back-to-back issue
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE: in_ready = 1'b1;
         HOLD: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: ;
      endcase
   end

   // Opcode decode into adder B / carry-in; reserved codes run as ADD
   always_comb begin
      w_b   = b;
      w_cin = 1'b0;
      w_cmp = 1'b0;
      w_rsv = 1'b0;
      case (op)
         OPW'(0): ;
         OPW'(1): w_cin = r_c;
         OPW'(2): begin
            w_b   = ~b;
            w_cin = 1'b1;
         end
         OPW'(3): begin
            w_b   = ~b;
            w_cin = r_c;
         end
         OPW'(4): begin
            w_b   = ~b;
            w_cin = 1'b1;
            w_cmp = 1'b1;
         end
         OPW'(5): begin
            w_b   = '0;
            w_cin = 1'b1;
         end
         default: w_rsv = 1'b1;
      endcase
   end

   // Operand registers load on accept and hold until the next one
   always_ff @(posedge clk) begin
      if (rst) begin
         r_add_a   <= '0;
         r_add_b   <= '0;
         r_add_cin <= 1'b0;
         r_cmp     <= 1'b0;
         r_rsv     <= 1'b0;
      end else if (w_accept) begin
         r_add_a   <= a;
         r_add_b   <= w_b;
         r_add_cin <= w_cin;
         r_cmp     <= w_cmp;
         r_rsv     <= w_rsv;
      end
   end

   // Capture sum and flags one edge after accept; CMP keeps old result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= '0;
         r_n      <= 1'b0;
         r_z      <= 1'b0;
         r_c      <= 1'b0;
         r_v      <= 1'b0;
         r_err    <= 1'b0;
      end else if (r_state == BUSY) begin
         if (!r_cmp) r_result <= add_sum;
         r_n   <= add_n;
         r_z   <= add_z;
         r_c   <= add_cout;
         r_v   <= w_v;
         r_err <= r_rsv;
      end
   end

   assign add_a   = r_add_a;
   assign add_b   = r_add_b;
   assign add_cin = r_add_cin;
   assign result  = r_result;
   assign flag_n  = r_n;
   assign flag_z  = r_z;
   assign flag_c  = r_c;
   assign flag_v  = r_v;
   assign op_err  = r_err;

endmodule

// File: tb/tb_alu_addsub_stage.sv
// Directed bench for alu_addsub_stage with a behavioural adder model.
// Expected values are hand-computed constants.
module tb_alu_addsub_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_cin;
   logic [31:0] add_sum;
   logic        add_cout;
   logic        add_z;
   logic        add_n;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        flag_n;
   logic        flag_z;
   logic        flag_c;
   logic        flag_v;
   logic        op_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // External adder stand-in
   always_comb begin
      {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
      add_z = (add_sum == 32'd0);
      add_n = add_sum[31];
   end

   alu_addsub_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .add_z(add_z), .add_n(add_n),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result),
      .flag_n(flag_n), .flag_z(flag_z),
      .flag_c(flag_c), .flag_v(flag_v),
      .op_err(op_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic [3:0] exp);
      chk(tag, {28'd0, flag_n, flag_z, flag_c, flag_v}, {28'd0, exp});
   endtask

   // Drive one op, require acceptance, check BUSY, then wait for capture
   task automatic issue(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y);
      op = o; a = x; b = y; in_valid = 1'b1;
      #1;
      chk("in_ready_pre", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
      chk("busy_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("out_valid", {31'd0, out_valid}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk_flags("rst_flags", 4'b0000);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_add_a", add_a, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      issue(3'd0, 32'hff000f0f, 32'h00fff0f0);
      chk("add1_res", result, 32'hffffffff);
      chk_flags("add1_nzcv", 4'b1000);
      chk("add1_err", {31'd0, op_err}, 32'd0);

      issue(3'd2, 32'd5, 32'd5);
      chk("sub_res", result, 32'd0);
      chk_flags("sub_nzcv", 4'b0110);
      chk("sub_add_b", add_b, 32'hfffffffa);

      issue(3'd4, 32'd3, 32'd7);
      chk("cmp_res", result, 32'd0);
      chk_flags("cmp_nzcv", 4'b1000);

      issue(3'd0, 32'h7fffffff, 32'd1);
      chk("ovf_res", result, 32'h80000000);
      chk_flags("ovf_nzcv", 4'b1001);

      issue(3'd0, 32'hffffffff, 32'd1);
      chk("wrap_res", result, 32'd0);
      chk_flags("wrap_nzcv", 4'b0110);

      issue(3'd1, 32'd0, 32'd0);
      chk("adc_cin", {31'd0, add_cin}, 32'd1);
      chk("adc_res", result, 32'd1);
      chk_flags("adc_nzcv", 4'b0000);

      issue(3'd3, 32'd10, 32'd3);
      chk("sbc_res", result, 32'd6);
      chk_flags("sbc_nzcv", 4'b0010);

      issue(3'd0, 32'h10, 32'h20);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_res", result, 32'h30);
         chk_flags("bp_nzcv", 4'b0000);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      issue(3'd5, 32'h41, 32'h1234);
      chk("inc_res", result, 32'h42);
      chk_flags("inc_nzcv", 4'b0000);

      issue(3'd7, 32'd2, 32'd3);
      chk("rsv_res", result, 32'd5);
      chk("rsv_err", {31'd0, op_err}, 32'd1);
      issue(3'd0, 32'd1, 32'd2);
      chk("clr_res", result, 32'd3);
      chk("clr_err", {31'd0, op_err}, 32'd0);

      op = 3'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_res", result, 32'd0);
      chk_flags("mid_rst_nzcv", 4'b0000);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_add_a", add_a, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("drop_valid", {31'd0, out_valid}, 32'd0);
      chk("drop_res", result, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_addsub_stage.md
Name: alu_addsub_stage

Overview:
- Operand-issue and flag-capture stage wrapped around the 32-bit ripple full adder (FA_32bit).
- Accepts an operation and two operands over a valid/ready handshake. Drives the adder's A, B and Cin: B is inverted for subtract, and carry-in comes from the stored C flag for ADC/SBC.
- Registers the adder's Sum, Cout, Z and N, computes V, and presents the result with NZCV flags downstream over a second valid/ready handshake.
- The adder stays external and is wired to the add_* ports.

Parameters:
- WIDTH, 32, datapath width; must equal the adder width.
- OPW, 3, opcode width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has an operation.
- in_ready  out  1  stage can accept an operation this cycle.
- op  in  OPW  operation code.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- add_a  out  WIDTH  to adder A.
- add_b  out  WIDTH  to adder B, after inversion/forcing.
- add_cin  out  1  to adder Cin.
- add_sum  in  WIDTH  from adder Sum.
- add_cout  in  1  from adder Cout.
- add_z  in  1  from adder Z.
- add_n  in  1  from adder N.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH  registered result.
- flag_n, flag_z, flag_c, flag_v  out  1 each  registered NZCV flags.
- op_err  out  1  last operation used a reserved opcode.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - result, flags, op_err, add_a, add_b, add_cin all cleared to 0; out_valid=0.
  - Reset overrides everything, including mid-BUSY and mid-HOLD; any in-flight operation is dropped.
- States and transitions:
  - IDLE: in_ready=1. On in_valid -> BUSY.
  - BUSY: operands are held in the operand registers and the adder settles combinationally. At the next edge, capture results and flags -> HOLD. in_ready=0.
  - HOLD: out_valid=1; result and flags are held stable.
    - out_ready=1 and in_valid=1: accept the new operation in the same cycle -> BUSY.
    - out_ready=1 and in_valid=0: -> IDLE.
    - out_ready=0: stay in HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). This is combinational on out_ready, which is intentional.
- Latency and throughput:
  - Accept at edge t (in_valid & in_ready).
  - add_a/add_b/add_cin are valid from t until the next accept.
  - Capture at edge t+1; out_valid is high after t+1.
  - Sustained throughput is one operation per 2 cycles.
- Operand mapping (add_b, add_cin):
  - 000 ADD: b, 0.
  - 001 ADC: b, flag_c.
  - 010 SUB: ~b, 1.
  - 011 SBC: ~b, flag_c.
  - 100 CMP: ~b, 1.
  - 101 INC: 0, 1. For INC, b is ignored.
  - 110, 111 reserved: executed as ADD with op_err=1. op_err=0 for all other ops.
  - add_a = a for all ops.
- flag_c used by ADC/SBC is the value registered at the accept edge, i.e. from the previous completed operation; back-to-back chaining is therefore correct.
- Capture rules:
  - flag_c = add_cout. For SUB/SBC/CMP, C=1 means no borrow.
  - flag_z = add_z; flag_n = add_n.
  - flag_v = (add_a[W-1] == add_b[W-1]) & (add_sum[W-1] != add_a[W-1]), using the registered operands.
  - result = add_sum, except CMP: result keeps its previous value; flags are updated.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- Flags change only at capture. They are stable through HOLD and IDLE.

Test Plan:
- ADD a=0xff000f0f b=0x00fff0f0 accepted at edge t -> at t+1 out_valid=1, result=0xffffffff, N=1 Z=0 C=0 V=0, op_err=0.
- SUB a=5 b=5 -> result=0, Z=1 C=1 N=0 V=0. Then CMP a=3 b=7 -> result stays 0, N=1 C=0 Z=0 V=0.
- ADD 0x7fffffff+0x00000001 -> result=0x80000000, N=1 V=1 C=0. Then ADD 0xffffffff+0x00000001 -> result=0, Z=1 C=1 V=0. Then ADC 0+0 -> result=1, C=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in HOLD -> result/flags unchanged, in_ready=0.
  - Then raise out_ready=1 with in_valid=1 (op INC a=0x41) in the same cycle -> accepted immediately; next result=0x42.
- Reserved op=111, a=2 b=3 -> result=5, op_err=1. Next op=000 clears op_err to 0.
- Assert rst in BUSY after accepting ADD 1+1 -> next edge: out_valid=0, result=0, all flags 0, in_ready=1. The dropped operation never appears.
